ldm_scan_ctrl: RTL and testbench
================================

// Module: ldm_scan_ctrl
// PURPOSE
//  Parametrised LED dot-matrix row-scan controller. For each row it fetches
//  column data from a frame-buffer read port, shifts it serially to the column
//  drivers, blanks, latches, then drives the row address and display enable.
//  Sits between the frame buffer and the LDM pins.
//  Generalises the fixed 16-row address/clock sequencer: adds a data path,
//  latch/blank control, configurable timing and optional brightness.
// PARAMETERS
//  NUM_ROWS   16  rows scanned, 2..256; ADDR_W = $clog2(NUM_ROWS) (localparam)
//  COL_W      16  column bits shifted per row, >= 1
//  DIV        4   clk cycles per ldm_clk half-period, >= 1
//  BLANK_CYC  2   clk cycles with oe_n high before latch, >= 1
//  DISP_CYC   64  clk cycles in the DISPLAY phase, >= 1
// PORTS
//  clk         in   1       system clock
//  rstn        in   1       asynchronous active-low reset
//  en          in   1       scan enable
//  rd_en       out  1       frame-buffer read strobe, 1 cycle
//  rd_addr     out  ADDR_W  row being fetched
//  rd_data     in   COL_W   row data, valid the cycle after rd_en
//  ldm_clk     out  1       column shift clock
//  ldm_dat     out  1       column serial data, MSB first
//  ldm_lat     out  1       column latch strobe
//  ldm_oe_n    out  1       display enable, active low
//  ldm_addr    out  ADDR_W  displayed row address
//  busy        out  1       high in any state other than IDLE
//  frame_done  out  1       1-cycle pulse after the last row's DISPLAY
//  brightness  in   BRT_W   only with LDM_BRIGHTNESS_EN; BRT_W=$clog2(DISP_CYC+1)
// BEHAVIOUR
//  Reset: all outputs 0 except ldm_oe_n=1; row counter 0; state IDLE.
//  Reset mid-operation aborts immediately to these values.
//  Interface: rstn asynchronous, active-low; clock clk.
//  FSM: IDLE -> FETCH -> SHIFT -> BLANK -> LATCH -> DISPLAY -> FETCH|IDLE.
//  IDLE: leave when en=1 (sampled); row counter restarts at 0.
//  FETCH (2 cyc): cyc0 rd_en=1, rd_addr=row; cyc1 capture rd_data into shreg.
//  SHIFT (2*DIV*COL_W cyc): per bit ldm_dat=shreg MSB, ldm_clk low DIV cyc,
//   then high DIV cyc; shreg shifts left at the end of the high phase.
//   ldm_dat changes only while ldm_clk=0; ldm_clk=0 on exit.
//  BLANK (BLANK_CYC cyc): ldm_oe_n=1; ldm_addr<=row on entry.
//  LATCH (DIV cyc): ldm_lat=1; ldm_oe_n stays 1.
//  DISPLAY (DISP_CYC cyc): ldm_oe_n=0; ldm_lat=0.
//  Row end: row==NUM_ROWS-1 -> row<=0, frame_done=1 next cycle; else row+1.
//   Non-power-of-2 NUM_ROWS wraps at NUM_ROWS-1, never at 2**ADDR_W.
//  en=0 mid-row: current row completes through DISPLAY, then IDLE with
//   ldm_oe_n=1; ldm_addr holds. en=1 at row end continues without gap.
//  Cycles per row: 2 + 2*DIV*COL_W + BLANK_CYC + DIV + DISP_CYC.
// CONFIGURATION
//  LDM_BRIGHTNESS_EN defined: brightness port present, sampled on DISPLAY
//   entry; ldm_oe_n=0 for the first min(brightness,DISP_CYC) DISPLAY cycles,
//   1 for the rest; DISPLAY length remains DISP_CYC. brightness=0 -> dark row.
//  Undefined: no brightness port; ldm_oe_n=0 for all DISP_CYC cycles.
// STRUCTURE
//  ldm_pkg: state enum (S_IDLE..S_DISPLAY), phase-length functions.
//  Sub-module ldm_clk_div: DIV-cycle phase counter producing half-period
//   tick; reused in SHIFT and LATCH.
// TESTING (NUM_ROWS=4, COL_W=8, DIV=2, BLANK_CYC=2, DISP_CYC=8 -> 46 cyc/row)
//  Reset during SHIFT -> oe_n=1, clk/dat/lat/addr=0, busy=0 in the same cycle.
//  en=1, rd_data=8'hA5 -> ldm_dat bits 1,0,1,0,0,1,0,1 sampled on 8 rising
//   ldm_clk edges; each ldm_clk high/low lasts 2 cycles.
//  Continuous en=1 -> ldm_addr 0,1,2,3,0; frame_done every 184 cycles.
//  NUM_ROWS=3 -> rd_addr sequence 0,1,2,0; addr 3 never issued.
//  en dropped in SHIFT of row 1 -> row 1 completes DISPLAY, IDLE, oe_n=1.
//  LDM_BRIGHTNESS_EN, brightness=3 -> oe_n low for 3 of 8 DISPLAY cycles;
//   brightness=0 -> oe_n never low; brightness=15 -> low all 8 cycles.

Source files
------------

// File: rtl/ldm_pkg.sv
// Shared state encoding and phase-length helpers for the LDM row-scan controller.
package ldm_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  localparam int FETCH_CYC = 2;

  function automatic int shift_cycles(input int div, input int col_w);
    return 2 * div * col_w;
  endfunction

  function automatic int row_cycles(input int div, input int col_w,
                                    input int blank_cyc, input int disp_cyc);
    return FETCH_CYC + shift_cycles(div, col_w) + blank_cyc + div + disp_cyc;
  endfunction

endpackage

// File: rtl/ldm_clk_div.sv
// Half-period phase counter: tick marks the last of every DIV cycles while run is high.
module ldm_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!run || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ldm_scan_ctrl.sv
// LED dot-matrix row-scan controller: fetch, shift, blank, latch and display each row.
// Defining LDM_BRIGHTNESS_EN adds a brightness port limiting the lit part of DISPLAY.
module ldm_scan_ctrl
  import ldm_pkg::*;
#(
  parameter int NUM_ROWS  = 16,
  parameter int COL_W     = 16,
  parameter int DIV       = 4,
  parameter int BLANK_CYC = 2,
  parameter int DISP_CYC  = 64
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  output logic                        rd_en,
  output logic [$clog2(NUM_ROWS)-1:0] rd_addr,
  input  logic [COL_W-1:0]            rd_data,
  output logic                        ldm_clk,
  output logic                        ldm_dat,
  output logic                        ldm_lat,
  output logic                        ldm_oe_n,
  output logic [$clog2(NUM_ROWS)-1:0] ldm_addr,
  output logic                        busy,
  output logic                        frame_done
`ifdef LDM_BRIGHTNESS_EN
  ,
  input  logic [$clog2(DISP_CYC+1)-1:0] brightness
`endif
);

  localparam int ADDR_W  = $clog2(NUM_ROWS);
  localparam int BIT_W   = (COL_W > 1) ? $clog2(COL_W) : 1;
  localparam int CNT_MAX = (DISP_CYC > BLANK_CYC) ? DISP_CYC : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NUM_ROWS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] row;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  cyc_cnt;
  logic [COL_W-1:0]  shreg;
  logic              div_run, div_tick, shift_edge, bit_done, row_done;

  ldm_clk_div #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rstn (rstn),
    .run  (div_run),
    .tick (div_tick)
  );

  // shift_edge is the end of an ldm_clk high phase: one column bit consumed
  assign shift_edge = (state == S_SHIFT) && div_tick && ldm_clk;
  assign bit_done   = shift_edge && (bit_cnt == BIT_W'(COL_W - 1));
  assign row_done   = (state == S_DISPLAY) && (cyc_cnt == CNT_W'(DISP_CYC - 1));

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    div_run   = 1'b0;
    case (state)
      S_IDLE: if (en) state_nxt = S_FETCH;
      S_FETCH: begin
        rd_en = (cyc_cnt == '0);
        if (cyc_cnt == CNT_W'(FETCH_CYC - 1)) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        div_run = 1'b1;
        if (bit_done) state_nxt = S_BLANK;
      end
      S_BLANK: if (cyc_cnt == CNT_W'(BLANK_CYC - 1)) state_nxt = S_LATCH;
      S_LATCH: begin
        div_run = 1'b1;
        if (div_tick) state_nxt = S_DISPLAY;
      end
      S_DISPLAY: if (row_done) state_nxt = en ? S_FETCH : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      row        <= '0;
      bit_cnt    <= '0;
      cyc_cnt    <= '0;
      ldm_clk    <= 1'b0;
      ldm_addr   <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= row_done && (row == LAST_ROW);
      if (state_nxt != state || state == S_IDLE || state == S_SHIFT) begin
        cyc_cnt <= '0;
      end else begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end
      if (state == S_IDLE) begin
        row <= '0;
      end else if (row_done) begin
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end
      if (state == S_SHIFT && div_tick) ldm_clk <= ~ldm_clk;
      if (bit_done) begin
        bit_cnt <= '0;
      end else if (shift_edge) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == S_SHIFT && state_nxt == S_BLANK) ldm_addr <= row;
    end
  end

  // Column data needs no reset: ldm_dat is gated by the SHIFT state
  always_ff @(posedge clk) begin
    if (state == S_FETCH && cyc_cnt == CNT_W'(FETCH_CYC - 1)) begin
      shreg <= rd_data;
    end else if (shift_edge) begin
      shreg <= shreg << 1;
    end
  end

  assign rd_addr = row;
  assign ldm_dat = (state == S_SHIFT) && shreg[COL_W-1];
  assign ldm_lat = (state == S_LATCH);
  assign busy    = (state != S_IDLE);

`ifdef LDM_BRIGHTNESS_EN
  localparam int BRT_W = $clog2(DISP_CYC + 1);

  logic [CNT_W-1:0] brt_q;

  function automatic logic [CNT_W-1:0] sat_brt(input logic [BRT_W-1:0] b);
    return (b > BRT_W'(DISP_CYC)) ? CNT_W'(DISP_CYC) : CNT_W'(b);
  endfunction

  always_ff @(posedge clk) begin
    if (state == S_LATCH && state_nxt == S_DISPLAY) brt_q <= sat_brt(brightness);
  end

  assign ldm_oe_n = !((state == S_DISPLAY) && (cyc_cnt < brt_q));
`else
  assign ldm_oe_n = (state != S_DISPLAY);
`endif

endmodule

// File: tb/tb_ldm_scan_ctrl.sv
// Scoreboard bench for ldm_scan_ctrl (4-row and 3-row instances, 46 cycles per row).
module tb_ldm_scan_ctrl;

  localparam int NR    = 4;
  localparam int COLW  = 8;
  localparam int DIV   = 2;
  localparam int BLANK = 2;
  localparam int DISP  = 8;
  localparam int FRAME = 184;

  logic       clk = 1'b0;
  logic       rstn, en;
  logic       rd_en, ldm_clk, ldm_dat, ldm_lat, ldm_oe_n, busy, frame_done;
  logic [1:0] rd_addr, ldm_addr;
  logic [7:0] rd_data = 8'h00;

  logic       rd_en3, ldm_clk3, ldm_dat3, ldm_lat3, ldm_oe_n3, busy3, frame_done3;
  logic [1:0] rd_addr3, ldm_addr3;
  logic [7:0] rd_data3 = 8'h00;

`ifdef LDM_BRIGHTNESS_EN
  logic [3:0] brightness;
`endif

  logic [7:0] fb [4];
  logic       chk_idle, fin;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ldm_scan_ctrl #(.NUM_ROWS(NR), .COL_W(COLW), .DIV(DIV), .BLANK_CYC(BLANK),
                  .DISP_CYC(DISP)) dut (
    .clk(clk), .rstn(rstn), .en(en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .ldm_clk(ldm_clk), .ldm_dat(ldm_dat), .ldm_lat(ldm_lat),
    .ldm_oe_n(ldm_oe_n), .ldm_addr(ldm_addr), .busy(busy), .frame_done(frame_done)
`ifdef LDM_BRIGHTNESS_EN
    , .brightness(brightness)
`endif
  );

  ldm_scan_ctrl #(.NUM_ROWS(3), .COL_W(COLW), .DIV(DIV), .BLANK_CYC(BLANK),
                  .DISP_CYC(DISP)) dut3 (
    .clk(clk), .rstn(rstn), .en(en), .rd_en(rd_en3), .rd_addr(rd_addr3),
    .rd_data(rd_data3), .ldm_clk(ldm_clk3), .ldm_dat(ldm_dat3), .ldm_lat(ldm_lat3),
    .ldm_oe_n(ldm_oe_n3), .ldm_addr(ldm_addr3), .busy(busy3), .frame_done(frame_done3)
`ifdef LDM_BRIGHTNESS_EN
    , .brightness(brightness)
`endif
  );

  // Frame-buffer read port: data appears the cycle after the strobe
  always @(posedge clk) begin
    rd_data  <= rd_en  ? fb[rd_addr]  : 8'h00;
    rd_data3 <= rd_en3 ? fb[rd_addr3] : 8'h00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int brt_exp();
`ifdef LDM_BRIGHTNESS_EN
    return (int'(brightness) < DISP) ? int'(brightness) : DISP;
`else
    return DISP;
`endif
  endfunction

  logic q_bits [$];
  int   q_addr [$];
  logic p_clk = 1'b0, p_lat = 1'b0, p_busy = 1'b0, dwin = 1'b0;
  int   cyc = 0, ref_cyc = 0, hi_len = 0, lo_len = 0, lat_len = 0, rise_cnt = 0;
  int   dpos = 0, exp_low = DISP, nframes = 0, nbits = 0, model_row = 0, model_row3 = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      chk("rst_oe_n", ldm_oe_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ldm_clk", ldm_clk, 0);
      chk("rst_ldm_dat", ldm_dat, 0);
      chk("rst_ldm_lat", ldm_lat, 0);
      chk("rst_ldm_addr", ldm_addr, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_frame_done", frame_done, 0);
      q_bits.delete();
      q_addr.delete();
      p_clk = 1'b0; p_lat = 1'b0; p_busy = 1'b0; dwin = 1'b0;
      hi_len = 0; lo_len = 0; lat_len = 0; rise_cnt = 0;
      model_row = 0; model_row3 = 0;
    end else begin
      if (!busy) model_row = 0;
      if (!busy3) model_row3 = 0;
      if (busy && !p_busy) ref_cyc = cyc;
      if (rd_en) begin
        chk("rd_addr", rd_addr, model_row);
        model_row = (model_row + 1) % NR;
        for (int i = COLW - 1; i >= 0; i--) q_bits.push_back(fb[rd_addr][i]);
        q_addr.push_back(int'(rd_addr));
      end
      if (rd_en3) begin
        chk("rd_addr3", rd_addr3, model_row3);
        model_row3 = (model_row3 + 1) % 3;
      end
      if (ldm_clk && !p_clk) begin
        if (q_bits.size() == 0) chk("bit_underflow", 1, 0);
        else chk("ldm_dat", ldm_dat, q_bits.pop_front());
        if (rise_cnt != 0) chk("clk_low_len", lo_len, DIV);
        rise_cnt = (rise_cnt + 1) % COLW;
        nbits++;
        hi_len = 0;
      end
      if (!ldm_clk && p_clk) begin
        chk("clk_high_len", hi_len, DIV);
        lo_len = 0;
      end
      if (ldm_clk) hi_len++; else lo_len++;
      if (ldm_lat && !p_lat) begin
        chk("lat_oe_n", ldm_oe_n, 1);
        chk("lat_ldm_clk", ldm_clk, 0);
        if (q_addr.size() == 0) chk("addr_underflow", 1, 0);
        else chk("ldm_addr", ldm_addr, q_addr.pop_front());
        chk("bits_left", q_bits.size(), 0);
        lat_len = 0;
      end
      if (!ldm_lat && p_lat) begin
        chk("lat_len", lat_len, DIV);
        dwin = 1'b1;
        dpos = 0;
        exp_low = brt_exp();
      end
      if (ldm_lat) lat_len++;
      if (dwin) begin
        chk("oe_n_display", ldm_oe_n, (dpos < exp_low) ? 0 : 1);
        if (dpos == DISP) dwin = 1'b0;
        else dpos++;
      end
      if (frame_done) begin
        chk("frame_period", cyc - ref_cyc, FRAME);
        ref_cyc = cyc;
        nframes++;
      end
      if (chk_idle) begin
        chk("idle_busy", busy, 0);
        chk("idle_oe_n", ldm_oe_n, 1);
        chk("idle_ldm_addr", ldm_addr, 1);
        chk("idle_addr_queue", q_addr.size(), 0);
      end
      if (fin) begin
        chk("frames_seen", nframes, 2);
        chk("bits_seen_min64", nbits >= 64, 1);
      end
      p_clk  = ldm_clk;
      p_lat  = ldm_lat;
      p_busy = busy;
    end
  end

  initial begin
    rstn = 1'b1; en = 1'b0; chk_idle = 1'b0; fin = 1'b0;
`ifdef LDM_BRIGHTNESS_EN
    brightness = 4'd15;
`endif
    fb[0] = 8'hA5; fb[1] = 8'h3C; fb[2] = 8'hF0; fb[3] = 8'h81;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1; en = 1'b1;
    // two full frames, then reset lands mid-SHIFT of row 0 with ldm_clk high
    repeat (385) @(posedge clk);
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    // drop en during SHIFT of row 1; row 1 must still finish
    repeat (61) @(posedge clk);
    #1 en = 1'b0;
    repeat (100) @(posedge clk);
    #1 chk_idle = 1'b1;
    @(posedge clk);
    #1 chk_idle = 1'b0;
`ifdef LDM_BRIGHTNESS_EN
    brightness = 4'd3;
`endif
    en = 1'b1;
    repeat (20) @(posedge clk);
    #1 en = 1'b0;
    repeat (60) @(posedge clk);
`ifdef LDM_BRIGHTNESS_EN
    #1 brightness = 4'd0;
`else
    #1;
`endif
    en = 1'b1;
    repeat (20) @(posedge clk);
    #1 en = 1'b0;
    repeat (60) @(posedge clk);
    #1 fin = 1'b1;
    @(posedge clk);
    #1 fin = 1'b0;
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
